// File: rtl/mat_stream_feeder.sv
// mat_stream_feeder
//   Stream-side partner of the 2x2 matrix compute core. Operand A (2xK) and
//   B (Kx2), both row-major, are written into local buffers while idle. A
//   launch raises start, streams A and then B out over AXI-Stream, collects
//   the four-beat C result, then drops start for one cycle and reports status.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data operand buffer writes (sel 0 = A, 1 = B), IDLE only
//   cfg_k, launch, done_clr      job size, job request, status clear
//   busy, done, err, err_code    status (err_code: 001 bad K, 010 early tlast,
//                                011 missing tlast, 100 timeout)
//   start                        level request to the compute core
//   m_axis_a_*, m_axis_b_*       operand streams out
//   s_axis_c_*                   result stream in
//   c_rd_idx, c_rd_data          combinational read of the captured C words
//
// Optional build macro
//   FEEDER_TIMEOUT_EN : adds a RECV_C watchdog of TIMEOUT_CYC idle cycles.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for launch, buffer writes accepted
// S_SEND_A | streaming A_buf[0 .. 2K-1]
// S_SEND_B | streaming B_buf[0 .. 2K-1]
// S_RECV_C | accepting the four C words
// S_FINISH | start low for one cycle so the core can leave DONE

module mat_stream_feeder #(
  parameter int DATA_W      = 32,
  parameter int K_MAX       = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [$clog2(2*K_MAX)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [15:0]                   cfg_k,
  input  logic                          launch,
  input  logic                          done_clr,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [2:0]                    err_code,
  output logic                          start,
  output logic [DATA_W-1:0]             m_axis_a_tdata,
  output logic                          m_axis_a_tvalid,
  input  logic                          m_axis_a_tready,
  output logic                          m_axis_a_tlast,
  output logic [DATA_W-1:0]             m_axis_b_tdata,
  output logic                          m_axis_b_tvalid,
  input  logic                          m_axis_b_tready,
  output logic                          m_axis_b_tlast,
  input  logic [DATA_W-1:0]             s_axis_c_tdata,
  input  logic                          s_axis_c_tvalid,
  output logic                          s_axis_c_tready,
  input  logic                          s_axis_c_tlast,
  input  logic [1:0]                    c_rd_idx,
  output logic [DATA_W-1:0]             c_rd_data
);

  localparam int AW = $clog2(2*K_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SEND_A, S_SEND_B, S_RECV_C, S_FINISH} state_t;

  state_t              state_q;
  logic [15:0]         k_q;
  logic [AW-1:0]       a_idx_q, b_idx_q;
  logic [1:0]          c_idx_q;
  logic                busy_q, done_q, err_q, start_q;
  logic                a_valid_q, b_valid_q, c_ready_q;
  logic [2:0]          err_code_q;
  logic [DATA_W-1:0]   a_buf_q [2*K_MAX];
  logic [DATA_W-1:0]   b_buf_q [2*K_MAX];
  logic [DATA_W-1:0]   c_res_q [4];
  logic [16:0]         last_idx;
  logic                a_hs, b_hs, c_hs, a_last, b_last;

`ifdef FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0]       wd_q;
`endif

  assign last_idx = {k_q, 1'b0} - 17'd1;
  assign a_last   = (17'(a_idx_q) == last_idx);
  assign b_last   = (17'(b_idx_q) == last_idx);
  assign a_hs     = a_valid_q & m_axis_a_tready;
  assign b_hs     = b_valid_q & m_axis_b_tready;
  assign c_hs     = c_ready_q & s_axis_c_tvalid;

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign err_code        = err_code_q;
  assign start           = start_q;
  assign m_axis_a_tvalid = a_valid_q;
  assign m_axis_b_tvalid = b_valid_q;
  assign s_axis_c_tready = c_ready_q;
  // Data and last follow the index, which only moves on a handshake, so they
  // stay stable through stalls. tlast is gated so it reads 0 outside the phase.
  assign m_axis_a_tdata  = a_buf_q[a_idx_q];
  assign m_axis_b_tdata  = b_buf_q[b_idx_q];
  assign m_axis_a_tlast  = a_valid_q & a_last;
  assign m_axis_b_tlast  = b_valid_q & b_last;
  assign c_rd_data       = c_res_q[c_rd_idx];

  // Operand buffers carry no reset; they are plain storage.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE) begin
      if (wr_sel) b_buf_q[wr_addr] <= wr_data;
      else        a_buf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      a_idx_q    <= '0;
      b_idx_q    <= '0;
      c_idx_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'b000;
      start_q    <= 1'b0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      c_ready_q  <= 1'b0;
      for (int i = 0; i < 4; i++) c_res_q[i] <= '0;
`ifdef FEEDER_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      // Clear first so that any set below in the same cycle wins.
      if (done_clr) begin
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        err_code_q <= 3'b000;
      end
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            if (cfg_k == 16'd0 || 32'(cfg_k) > K_MAX) begin
              err_q      <= 1'b1;
              err_code_q <= 3'b001;
            end else begin
              k_q        <= cfg_k;
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              err_code_q <= 3'b000;
              a_idx_q    <= '0;
              b_idx_q    <= '0;
              c_idx_q    <= '0;
              busy_q     <= 1'b1;
              start_q    <= 1'b1;
              a_valid_q  <= 1'b1;
              state_q    <= S_SEND_A;
            end
          end
        end
        S_SEND_A: begin
          if (a_hs) begin
            if (a_last) begin
              a_valid_q <= 1'b0;
              b_valid_q <= 1'b1;
              state_q   <= S_SEND_B;
            end else begin
              a_idx_q <= a_idx_q + AW'(1);
            end
          end
        end
        S_SEND_B: begin
          if (b_hs) begin
            if (b_last) begin
              b_valid_q <= 1'b0;
              c_ready_q <= 1'b1;
              state_q   <= S_RECV_C;
`ifdef FEEDER_TIMEOUT_EN
              wd_q      <= WW'(TIMEOUT_CYC - 1);
`endif
            end else begin
              b_idx_q <= b_idx_q + AW'(1);
            end
          end
        end
        S_RECV_C: begin
          if (c_hs) begin
            c_res_q[c_idx_q] <= s_axis_c_tdata;
            c_idx_q          <= c_idx_q + 2'd1;
`ifdef FEEDER_TIMEOUT_EN
            wd_q             <= WW'(TIMEOUT_CYC - 1);
`endif
            if (s_axis_c_tlast && c_idx_q != 2'd3) begin
              err_q      <= 1'b1;
              err_code_q <= 3'b010;
              c_ready_q  <= 1'b0;
              start_q    <= 1'b0;
              state_q    <= S_FINISH;
            end else if (c_idx_q == 2'd3) begin
              if (s_axis_c_tlast) begin
                done_q <= 1'b1;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= 3'b011;
              end
              c_ready_q <= 1'b0;
              start_q   <= 1'b0;
              state_q   <= S_FINISH;
            end
          end
`ifdef FEEDER_TIMEOUT_EN
          // Down-counter reaching zero on an idle cycle is the terminal count.
          else if (wd_q == '0) begin
            err_q      <= 1'b1;
            err_code_q <= 3'b100;
            c_ready_q  <= 1'b0;
            start_q    <= 1'b0;
            state_q    <= S_FINISH;
          end else begin
            wd_q <= wd_q - WW'(1);
          end
`endif
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          start_q   <= 1'b0;
          a_valid_q <= 1'b0;
          b_valid_q <= 1'b0;
          c_ready_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_stream_feeder.sv
module tb_mat_stream_feeder;
  localparam int DW = 32;
  localparam int KM = 64;
  localparam int TO = 16;
  localparam int AW = $clog2(2*KM);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0, wr_sel = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic [15:0]     cfg_k = '0;
  logic            launch = 1'b0, done_clr = 1'b0;
  logic            busy, done, err, start;
  logic [2:0]      err_code;
  logic [DW-1:0]   a_data, b_data, c_data = '0, c_rd_data;
  logic            a_valid, a_ready = 1'b0, a_last;
  logic            b_valid, b_ready = 1'b0, b_last;
  logic            c_valid = 1'b0, c_ready, c_last = 1'b0;
  logic [1:0]      c_rd_idx = '0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mA [2*KM];
  logic [DW-1:0] mB [2*KM];
  logic [DW-1:0] mc [4];

  always #5 clk = ~clk;

  mat_stream_feeder #(.DATA_W(DW), .K_MAX(KM), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_k(cfg_k), .launch(launch), .done_clr(done_clr),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .start(start),
    .m_axis_a_tdata(a_data), .m_axis_a_tvalid(a_valid), .m_axis_a_tready(a_ready), .m_axis_a_tlast(a_last),
    .m_axis_b_tdata(b_data), .m_axis_b_tvalid(b_valid), .m_axis_b_tready(b_ready), .m_axis_b_tlast(b_last),
    .s_axis_c_tdata(c_data), .s_axis_c_tvalid(c_valid), .s_axis_c_tready(c_ready), .s_axis_c_tlast(c_last),
    .c_rd_idx(c_rd_idx), .c_rd_data(c_rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
  endfunction

  task automatic load(input int k, input bit directed);
    for (int i = 0; i < 2*k; i++) begin
      mA[i] = directed ? DW'(i + 1) : $urandom;
      mB[i] = directed ? DW'(i + 5) : $urandom;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(i); wr_data = mA[i];
      tick();
      wr_sel = 1'b1; wr_data = mB[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic check_c_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      c_rd_idx = 2'(i);
      #1;
      checks++;
      if (c_rd_data !== mc[i]) begin
        errors++;
        $display("FAIL %s c_rd_data[%0d] got %0d want %0d", tag, i, c_rd_data, mc[i]);
      end
    end
  endtask

  // c_mode: 0 good, 1 tlast on beat 1, 2 no tlast on beat 3, 3 C never valid
  task automatic run_job(input int k, input int a_mode, input int b_mode, input int c_mode,
                         input bit c_gaps, input bit junk,
                         output int t_bfirst, output int t_fin);
    logic [DW-1:0] ec [4];
    logic [DW-1:0] sum, a_pd, b_pd;
    logic a_pl, b_pl, a_st, b_st, fin_done, fin_err;
    logic [2:0] want_code;
    int ai, bi, ci, cyc, nb, t_recv, last_hs;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        sum = '0;
        for (int j = 0; j < k; j++) sum += mA[r*k + j] * mB[j*2 + c];
        ec[r*2 + c] = sum;
      end
    nb = (c_mode == 1) ? 2 : (c_mode == 3) ? 0 : 4;
    ai = 0; bi = 0; ci = 0; a_st = 0; b_st = 0; a_pd = '0; b_pd = '0; a_pl = 0; b_pl = 0;
    t_bfirst = -1; t_fin = -1; t_recv = -1; last_hs = -1; fin_done = 0; fin_err = 0;
    cfg_k = 16'(k); launch = 1'b1;
    tick();
    launch = 1'b0; cyc = 1;
    checks++;
    if (!(start === 1'b1 && a_valid === 1'b1 && busy === 1'b1)) begin
      errors++;
      $display("FAIL launch_latency start=%b a_valid=%b busy=%b want 1 1 1", start, a_valid, busy);
    end
    while (cyc < 3000) begin
      if (busy !== 1'b1) break;
      a_ready = rdy(a_mode, cyc);
      b_ready = rdy(b_mode, cyc);
      if (junk) begin
        wr_en = 1'b1; wr_sel = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom_range(0, 2*k - 1)); wr_data = $urandom;
      end
      if (ci < nb && (!c_gaps || $urandom_range(0, 1) == 1)) begin
        c_valid = 1'b1; c_data = ec[ci];
        c_last = (c_mode == 0 && ci == 3) || (c_mode == 1 && ci == 1);
      end else begin
        c_valid = 1'b0; c_last = 1'b0; c_data = $urandom;
      end
      if (a_valid === 1'b1) begin
        if (a_st) begin
          checks++;
          if (a_data !== a_pd || a_last !== a_pl) begin
            errors++;
            $display("FAIL a_stall_stable got %h/%b want %h/%b", a_data, a_last, a_pd, a_pl);
          end
        end
        checks++;
        if (ai >= 2*k) begin
          errors++;
          $display("FAIL a_extra_beat got beat %0d want at most %0d", ai, 2*k - 1);
        end else if (a_data !== mA[ai] || a_last !== (ai == 2*k - 1)) begin
          errors++;
          $display("FAIL a_beat%0d got %h/%b want %h/%b", ai, a_data, a_last, mA[ai], ai == 2*k - 1);
        end
        if (a_ready) begin ai++; a_st = 0; end
        else begin a_st = 1; a_pd = a_data; a_pl = a_last; end
      end
      if (b_valid === 1'b1) begin
        if (t_bfirst < 0) t_bfirst = cyc;
        if (b_st) begin
          checks++;
          if (b_data !== b_pd || b_last !== b_pl) begin
            errors++;
            $display("FAIL b_stall_stable got %h/%b want %h/%b", b_data, b_last, b_pd, b_pl);
          end
        end
        checks++;
        if (bi >= 2*k || ai != 2*k) begin
          errors++;
          $display("FAIL b_order got b beat %0d after %0d A beats want A complete", bi, ai);
        end else if (b_data !== mB[bi] || b_last !== (bi == 2*k - 1)) begin
          errors++;
          $display("FAIL b_beat%0d got %h/%b want %h/%b", bi, b_data, b_last, mB[bi], bi == 2*k - 1);
        end
        if (b_ready) begin bi++; b_st = 0; end
        else begin b_st = 1; b_pd = b_data; b_pl = b_last; end
      end
      if (c_ready === 1'b1 && t_recv < 0) t_recv = cyc;
      if (c_ready === 1'b1 && c_valid) begin
        mc[ci] = ec[ci]; ci++; last_hs = cyc;
      end
      if (start === 1'b0 && t_fin < 0) begin
        t_fin = cyc; fin_done = done; fin_err = err;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0; c_valid = 1'b0; c_last = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL job_budget got busy after %0d cycles want idle", cyc);
    end
    checks++;
    if (ai != 2*k || bi != 2*k) begin
      errors++;
      $display("FAIL beat_count got A=%0d B=%0d want %0d each", ai, bi, 2*k);
    end
    want_code = (c_mode == 0) ? 3'b000 : (c_mode == 1) ? 3'b010 : (c_mode == 2) ? 3'b011 : 3'b100;
    checks++;
    if (fin_done !== (c_mode == 0) || fin_err !== (c_mode != 0)) begin
      errors++;
      $display("FAIL finish_status got done=%b err=%b want done=%b err=%b", fin_done, fin_err, c_mode == 0, c_mode != 0);
    end
    checks++;
    if (done !== (c_mode == 0) || err !== (c_mode != 0) || err_code !== want_code) begin
      errors++;
      $display("FAIL idle_status got %b/%b/%b want %b/%b/%b", done, err, err_code, c_mode == 0, c_mode != 0, want_code);
    end
    checks++;
    if (c_mode == 3) begin
      if (t_fin != t_recv + TO) begin
        errors++;
        $display("FAIL timeout_cycle got %0d want %0d", t_fin - t_recv, TO);
      end
    end else if (t_fin != last_hs + 1) begin
      errors++;
      $display("FAIL finish_cycle got %0d want %0d", t_fin, last_hs + 1);
    end
    checks++;
    if (cyc != t_fin + 1) begin
      errors++;
      $display("FAIL busy_drop got cycle %0d want %0d", cyc, t_fin + 1);
    end
    check_c_regs("job");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, err, start, a_valid, a_last, b_valid, b_last, c_ready, err_code} !== 12'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {busy, done, err, start, a_valid, a_last, b_valid, b_last, c_ready, err_code});
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) mc[i] = '0;
    check_c_regs("reset");
  endtask

  task automatic test_directed_k2();
    int tb, tf;
    load(2, 1'b1);
    run_job(2, 0, 0, 0, 1'b0, 1'b0, tb, tf);
    checks++;
    if (tb != 5 || tf != 13) begin
      errors++;
      $display("FAIL k2_timing got b_first=%0d fin=%0d want 5 13", tb, tf);
    end
  endtask

  task automatic test_stall_pattern();
    int tb, tf;
    load(3, 1'b0);
    run_job(3, 2, 0, 0, 1'b0, 1'b0, tb, tf);
  endtask

  task automatic test_bad_k();
    cfg_k = 16'd0; launch = 1'b1;
    tick();
    launch = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || err_code !== 3'b001 || a_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL bad_k0 got busy=%b err=%b code=%b a_valid=%b done=%b want 0 1 001 0 1", busy, err, err_code, a_valid, done);
    end
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || err_code !== 3'b000) begin
      errors++;
      $display("FAIL done_clr got %b/%b/%b want 0/0/000", done, err, err_code);
    end
    cfg_k = 16'(KM + 1); launch = 1'b1; done_clr = 1'b1;
    tick();
    launch = 1'b0; done_clr = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || err_code !== 3'b001 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_k65 got busy=%b err=%b code=%b a_valid=%b want 0 1 001 0", busy, err, err_code, a_valid);
    end
  endtask

  task automatic test_c_errors();
    int tb, tf;
    load(2, 1'b0);
    run_job(2, 1, 1, 1, 1'b1, 1'b0, tb, tf);
    load(3, 1'b0);
    run_job(3, 1, 0, 2, 1'b1, 1'b0, tb, tf);
  endtask

  task automatic test_reset_mid();
    int tb, tf;
    load(3, 1'b0);
    a_ready = 1'b1; b_ready = 1'b1; cfg_k = 16'd3; launch = 1'b1;
    tick();
    launch = 1'b0;
    repeat (8) tick();
    checks++;
    if (b_valid !== 1'b1 || b_data !== mB[2]) begin
      errors++;
      $display("FAIL mid_setup got b_valid=%b data=%h want 1 %h", b_valid, b_data, mB[2]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({start, a_valid, b_valid, busy, c_ready, b_last, done, err} !== 8'b0) begin
      errors++;
      $display("FAIL mid_reset got %b want 0", {start, a_valid, b_valid, busy, c_ready, b_last, done, err});
    end
    tick();
    rst = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 4; i++) mc[i] = '0;
    tick();
    run_job(3, 1, 1, 0, 1'b1, 1'b0, tb, tf);
  endtask

  task automatic test_random();
    int tb, tf, k;
    for (int n = 0; n < 6; n++) begin
      k = $urandom_range(1, 8);
      load(k, 1'b0);
      run_job(k, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b1, 1'b0, tb, tf);
    end
    load(KM, 1'b0);
    run_job(KM, 1, 1, 0, 1'b1, 1'b0, tb, tf);
  endtask

  task automatic test_back_to_back();
    int tb, tf;
    load(4, 1'b0);
    run_job(4, 1, 1, 0, 1'b1, 1'b1, tb, tf);
    run_job(4, 0, 0, 0, 1'b0, 1'b0, tb, tf);
  endtask

`ifdef FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int tb, tf;
    load(2, 1'b0);
    run_job(2, 0, 0, 3, 1'b0, 1'b0, tb, tf);
  endtask
`endif

  initial begin
    test_reset();
    test_directed_k2();
    test_stall_pattern();
    test_bad_k();
    test_c_errors();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_stream_feeder.md
# mat_stream_feeder

- Stream master/slave counterpart of the 2x2 matrix compute core.
- Holds operand A (2xK, row-major) and B (Kx2, row-major) in local register buffers, written by the control side.
- On launch, it raises `start`, streams A then B over AXI-Stream, and collects the four-beat C result.
- It then drops `start` and reports done/error status to the AXI-Lite register block.

## Interface
Parameters:
- DATA_W, 32, beat width of A, B, C streams and buffers
- K_MAX, 64, maximum inner dimension; each operand buffer holds 2*K_MAX words
- TIMEOUT_CYC, 1024, idle cycles tolerated in RECV_C (only with FEEDER_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  operand buffer write strobe
- wr_sel  in  1  0 = A buffer, 1 = B buffer
- wr_addr  in  $clog2(2*K_MAX)  word index, row-major
- wr_data  in  DATA_W  write data
- cfg_k  in  16  inner dimension K, sampled on launch
- launch  in  1  single-cycle request to run one job
- done_clr  in  1  clears sticky done and err
- busy  out  1  state != IDLE
- done  out  1  sticky job-complete flag
- err  out  1  sticky error flag
- err_code  out  3  001 bad K, 010 early C tlast, 011 missing C tlast, 100 timeout
- start  out  1  level request to the compute core
- m_axis_a_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  A stream
- m_axis_b_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  B stream
- s_axis_c_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  C stream
- c_rd_idx  in  2  result select (row*2+col)
- c_rd_data  out  DATA_W  captured C word, combinational read of result registers

## Operation
- States: IDLE, SEND_A, SEND_B, RECV_C, FINISH.
- IDLE:
  - Buffer writes are accepted only here; writes in any other state are ignored.
  - On launch with 1 <= cfg_k <= K_MAX: latch K into k_q, clear done/err and all counters, go to SEND_A.
  - On launch with cfg_k == 0 or cfg_k > K_MAX: stay IDLE and set err with code 001. done is left unchanged.
- SEND_A:
  - start = 1; m_axis_a_tvalid = 1; tdata = A_buf[a_idx]; tlast = (a_idx == 2*k_q-1).
  - a_idx increments only on a tvalid&&tready handshake.
  - The handshake on the last beat moves the FSM to SEND_B.
- SEND_B:
  - Same rules as SEND_A, using B_buf, b_idx and the B ports.
  - The last handshake moves the FSM to RECV_C.
- RECV_C:
  - s_axis_c_tready = 1. Each handshake stores tdata into C_res[c_idx] and increments c_idx (0..3).
  - tlast with c_idx < 3: set err (010), go to FINISH.
  - c_idx == 3 without tlast: store the word, set err (011), go to FINISH.
  - c_idx == 3 with tlast: set done, go to FINISH.
- FINISH: start = 0 for exactly one cycle, then IDLE. This lets the core leave its DONE state.
- tvalid never depends on tready.
- tdata and tlast are held stable while tvalid && !tready, because the index moves only on handshake.
- done_clr clears done and err. If a set and a clear hit in the same cycle, the set wins.
- err_code holds the most recent error until cleared.
- C_res is not cleared by launch; it keeps the previous job's words until overwritten.

## Timing
- Reset values: state IDLE; busy, done, err, start, all tvalid, all tlast and s_axis_c_tready are 0; err_code 000; counters 0; C_res 0.
- Operand buffers are not reset.
- Launch accepted in cycle N: start and m_axis_a_tvalid are 1 in cycle N+1.
- With constant ready, A takes 2K cycles, B starts the cycle after the last A handshake, and B takes 2K cycles.
- There are no idle bubbles inside a stream.
- done and err become visible the cycle after the final C handshake, which is the same cycle as FINISH. busy goes low one cycle later.
- launch while busy is ignored.
- Reset asserted mid-job immediately returns all outputs to their reset values and abandons the job.

## Configuration
- FEEDER_TIMEOUT_EN defined:
  - A watchdog counts consecutive RECV_C cycles without a C handshake.
  - When the count reaches TIMEOUT_CYC, the block sets err (100) and goes to FINISH.
  - The count resets on every handshake.
- FEEDER_TIMEOUT_EN undefined: no watchdog; RECV_C waits indefinitely. Error code 100 never occurs.

## Test plan
- K=2, A={1,2,3,4}, B={5,6,7,8}, ready always 1, C returns {19,22,43,50} with tlast on beat 3:
  - A tlast on A beat 3, B tlast on B beat 3.
  - done=1; c_rd_data for indices 0..3 = 19, 22, 43, 50.
  - start drops for one cycle, then busy=0.
- K=3 with A tready toggling 1,0,0,1:
  - tdata/tlast are stable across every stalled cycle.
  - Exactly 6 A beats in order, tlast only on beat 5.
- launch with cfg_k=0, then with cfg_k=65 (K_MAX=64):
  - Stays IDLE, err=1, err_code=001, no tvalid asserted.
- C stream asserts tlast on beat 1 -> err=1, err_code=010, done=0, FINISH reached.
- With FEEDER_TIMEOUT_EN and TIMEOUT_CYC=16, C never valid -> err_code=100 sixteen cycles after RECV_C entry.
- rst pulsed during SEND_B beat 2 -> start=0, tvalid=0, busy=0 at once; a subsequent launch restarts from A beat 0.
